// File: rtl/ldst_compact_ctrl_if.sv
// Handshake and compactor-control bundle between the load/store issue queue
// controller (slave) and its environment (master).
interface ldst_compact_ctrl_if;
    logic       flush;
    logic       enq_valid;
    logic       enq_rdy;
    logic       enq_ready;
    logic [3:0] wake_vec;
    logic       issue_valid;
    logic [1:0] issue_slot;
    logic       issue_ready;
    logic [3:0] shift_sel;
    logic [3:0] shift_we;
    logic [3:0] enq_we;
    logic [2:0] count;
    logic       full;
    logic       empty;

    modport master (
        output flush, enq_valid, enq_rdy, wake_vec, issue_ready,
        input  enq_ready, issue_valid, issue_slot, shift_sel, shift_we,
               enq_we, count, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_rdy, wake_vec, issue_ready,
        output enq_ready, issue_valid, issue_slot, shift_sel, shift_we,
               enq_we, count, full, empty
    );
endinterface

// File: rtl/ldst_compact_ctrl.sv
// Sequencing for a 4-slot collapsing load/store issue queue: valid/ready
// tracking, oldest-first issue pick and compactor select/write-enable generation.
module ldst_compact_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    ldst_compact_ctrl_if.slave   bus
);

    logic [3:0] valid_r;
    logic [3:0] rdy_r;
    logic [2:0] count_r;

    logic [3:0] cand_s;
    logic       issue_valid_s;
    logic [1:0] issue_slot_s;
    logic       full_s;
    logic       enq_ready_s;
    logic       issue_fire_s;
    logic       enq_fire_s;
    logic [2:0] last_s;
    logic [2:0] tgt_s;
    logic [3:0] shift_s;
    logic [3:0] enq_we_s;
    logic [3:0] wake_eff_s;
    logic [4:0] valid_w_s;
    logic [4:0] rdy_w_s;
    logic [3:0] valid_nx_s;
    logic [3:0] rdy_nx_s;
    logic [2:0] count_nx_s;

    // Oldest-first pick among valid and ready slots.
    always_comb begin
        cand_s        = valid_r & rdy_r;
        issue_valid_s = |cand_s;
        if (cand_s[0]) begin
            issue_slot_s = 2'd0;
        end else if (cand_s[1]) begin
            issue_slot_s = 2'd1;
        end else if (cand_s[2]) begin
            issue_slot_s = 2'd2;
        end else if (cand_s[3]) begin
            issue_slot_s = 2'd3;
        end else begin
            issue_slot_s = 2'd0;
        end
    end

    // Handshake qualification; flush and reset suppress any fire even though
    // enq_ready/issue_valid still reflect the pre-flush state.
    always_comb begin
        full_s       = (count_r == 3'd4);
        enq_ready_s  = ~full_s | (issue_valid_s & bus.issue_ready);
        issue_fire_s = issue_valid_s & bus.issue_ready & ~bus.flush & rst_n;
        enq_fire_s   = bus.enq_valid & enq_ready_s & ~bus.flush & rst_n;
        last_s       = count_r - 3'd1;
        if (issue_fire_s) begin
            tgt_s = last_s;
        end else begin
            tgt_s = count_r;
        end
    end

    // Compactor controls: slots from the issued one up to the second-to-last
    // valid slot pull from their younger neighbour; enqueue writes the target.
    always_comb begin
        shift_s  = 4'b0000;
        enq_we_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            shift_s[i]  = issue_fire_s && (3'(i) >= {1'b0, issue_slot_s}) && (3'(i) < last_s);
            enq_we_s[i] = enq_fire_s && (tgt_s == 3'(i));
        end
    end

    // Next-state: ready bits (with same-cycle wakes) travel with the shift.
    always_comb begin
        wake_eff_s = bus.wake_vec & valid_r;
        valid_w_s  = {1'b0, valid_r};
        rdy_w_s    = {1'b0, rdy_r | wake_eff_s};
        valid_nx_s = valid_r;
        rdy_nx_s   = rdy_r;
        for (int i = 0; i < 4; i++) begin
            if (shift_s[i]) begin
                valid_nx_s[i] = valid_w_s[i + 1];
                rdy_nx_s[i]   = rdy_w_s[i + 1];
            end else if (issue_fire_s && (3'(i) == last_s)) begin
                valid_nx_s[i] = 1'b0;
                rdy_nx_s[i]   = 1'b0;
            end else begin
                valid_nx_s[i] = valid_w_s[i];
                rdy_nx_s[i]   = rdy_w_s[i];
            end
            if (enq_we_s[i]) begin
                valid_nx_s[i] = 1'b1;
                rdy_nx_s[i]   = bus.enq_rdy;
            end else begin
                valid_nx_s[i] = valid_nx_s[i];
            end
        end
        if (bus.flush) begin
            valid_nx_s = 4'b0000;
            rdy_nx_s   = 4'b0000;
            count_nx_s = 3'd0;
        end else begin
            count_nx_s = count_r + {2'b00, enq_fire_s} - {2'b00, issue_fire_s};
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 4'b0000;
            rdy_r   <= 4'b0000;
            count_r <= 3'd0;
        end else begin
            valid_r <= valid_nx_s;
            rdy_r   <= rdy_nx_s;
            count_r <= count_nx_s;
        end
    end

    assign bus.enq_ready   = enq_ready_s;
    assign bus.issue_valid = issue_valid_s;
    assign bus.issue_slot  = issue_slot_s;
    assign bus.shift_sel   = shift_s;
    assign bus.shift_we    = shift_s;
    assign bus.enq_we      = enq_we_s;
    assign bus.count       = count_r;
    assign bus.full        = full_s;
    assign bus.empty       = (count_r == 3'd0);

endmodule

// File: tb/tb_ldst_compact_ctrl.sv
// Directed bench for ldst_compact_ctrl with hand-computed expectations.
module tb_ldst_compact_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    ldst_compact_ctrl_if bus_i ();

    ldst_compact_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_i.flush       = 1'b0;
        bus_i.enq_valid   = 1'b0;
        bus_i.enq_rdy     = 1'b0;
        bus_i.wake_vec    = 4'b0000;
        bus_i.issue_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",      8'(bus_i.count),       8'd0);
        chk("rst_empty",      8'(bus_i.empty),       8'd1);
        chk("rst_full",       8'(bus_i.full),        8'd0);
        chk("rst_enq_ready",  8'(bus_i.enq_ready),   8'd1);
        chk("rst_issue_vld",  8'(bus_i.issue_valid), 8'd0);
        chk("rst_issue_slot", 8'(bus_i.issue_slot),  8'd0);
        chk("rst_shift_sel",  8'(bus_i.shift_sel),   8'd0);
        chk("rst_shift_we",   8'(bus_i.shift_we),    8'd0);
        chk("rst_enq_we",     8'(bus_i.enq_we),      8'd0);
        rst_n = 1'b1;
        step();

        // Fill with four not-ready entries
        bus_i.enq_valid = 1'b1;
        #1; chk("fill0_enq_we", 8'(bus_i.enq_we), 8'h01); step();
        chk("fill1_enq_we", 8'(bus_i.enq_we), 8'h02); step();
        chk("fill2_enq_we", 8'(bus_i.enq_we), 8'h04); step();
        chk("fill3_enq_we", 8'(bus_i.enq_we), 8'h08); step();
        bus_i.enq_valid = 1'b0;
        #1;
        chk("fill_count",     8'(bus_i.count),       8'd4);
        chk("fill_full",      8'(bus_i.full),        8'd1);
        chk("fill_enq_ready", 8'(bus_i.enq_ready),   8'd0);
        chk("fill_issue_vld", 8'(bus_i.issue_valid), 8'd0);
        chk("fill_enq_we_blk", 8'(bus_i.enq_we),     8'h00);

        // Wake slot 2, issue it
        bus_i.wake_vec = 4'b0100;
        step();
        bus_i.wake_vec = 4'b0000;
        #1;
        chk("w2_issue_vld",  8'(bus_i.issue_valid), 8'd1);
        chk("w2_issue_slot", 8'(bus_i.issue_slot),  8'd2);
        bus_i.issue_ready = 1'b1;
        #1;
        chk("i2_shift_sel", 8'(bus_i.shift_sel), 8'h04);
        chk("i2_shift_we",  8'(bus_i.shift_we),  8'h04);
        chk("i2_enq_we",    8'(bus_i.enq_we),    8'h00);
        step();
        bus_i.issue_ready = 1'b0;
        #1;
        chk("i2_count",     8'(bus_i.count),       8'd3);
        chk("i2_full",      8'(bus_i.full),        8'd0);
        chk("i2_issue_vld", 8'(bus_i.issue_valid), 8'd0);

        // Slots 0 and 2 ready, two back-to-back issues
        bus_i.wake_vec = 4'b0101;
        step();
        bus_i.wake_vec = 4'b0000;
        bus_i.issue_ready = 1'b1;
        #1;
        chk("oo_slot_a",    8'(bus_i.issue_slot), 8'd0);
        chk("oo_shift_a",   8'(bus_i.shift_sel),  8'h03);
        step();
        chk("oo_slot_b",    8'(bus_i.issue_slot),  8'd1);
        chk("oo_vld_b",     8'(bus_i.issue_valid), 8'd1);
        chk("oo_count_b",   8'(bus_i.count),       8'd2);
        chk("oo_shift_b",   8'(bus_i.shift_sel),   8'h00);
        step();
        bus_i.issue_ready = 1'b0;
        #1;
        chk("oo_count_c",   8'(bus_i.count),       8'd1);
        chk("oo_vld_c",     8'(bus_i.issue_valid), 8'd0);

        // Refill to four ready entries, waking slot 0 on the way
        bus_i.enq_valid = 1'b1;
        bus_i.enq_rdy   = 1'b1;
        bus_i.wake_vec  = 4'b0001;
        #1; chk("rf_enq_we", 8'(bus_i.enq_we), 8'h02);
        step();
        bus_i.wake_vec = 4'b0000;
        step();
        step();
        bus_i.enq_rdy = 1'b0;
        #1;
        chk("rf_count",      8'(bus_i.count),      8'd4);
        chk("rf_issue_slot", 8'(bus_i.issue_slot), 8'd0);
        chk("rf_enq_ready_blk", 8'(bus_i.enq_ready), 8'd0);

        // Full: issue slot 0 with simultaneous enqueue
        bus_i.issue_ready = 1'b1;
        #1;
        chk("fe_enq_ready", 8'(bus_i.enq_ready), 8'd1);
        chk("fe_shift_sel", 8'(bus_i.shift_sel), 8'h07);
        chk("fe_shift_we",  8'(bus_i.shift_we),  8'h07);
        chk("fe_enq_we",    8'(bus_i.enq_we),    8'h08);
        step();
        bus_i.issue_ready = 1'b0;
        bus_i.enq_valid   = 1'b0;
        #1;
        chk("fe_count",     8'(bus_i.count),      8'd4);
        chk("fe_issue_slot", 8'(bus_i.issue_slot), 8'd0);

        // Flush with pending enqueue and issuable entry
        bus_i.flush       = 1'b1;
        bus_i.enq_valid   = 1'b1;
        bus_i.issue_ready = 1'b1;
        #1;
        chk("fl_enq_ready", 8'(bus_i.enq_ready),   8'd1);
        chk("fl_issue_vld", 8'(bus_i.issue_valid), 8'd1);
        chk("fl_shift_we",  8'(bus_i.shift_we),    8'h00);
        chk("fl_shift_sel", 8'(bus_i.shift_sel),   8'h00);
        chk("fl_enq_we",    8'(bus_i.enq_we),      8'h00);
        step();
        idle_inputs();
        #1;
        chk("fl_count",     8'(bus_i.count),       8'd0);
        chk("fl_empty",     8'(bus_i.empty),       8'd1);
        chk("fl_issue_vld", 8'(bus_i.issue_valid), 8'd0);

        // Two entries (slot 1 ready), issue slot 1 + enqueue + wake slot 0
        bus_i.enq_valid = 1'b1;
        step();
        bus_i.enq_rdy = 1'b1;
        step();
        bus_i.enq_valid = 1'b0;
        bus_i.enq_rdy   = 1'b0;
        #1;
        chk("c2_count",      8'(bus_i.count),      8'd2);
        chk("c2_issue_slot", 8'(bus_i.issue_slot), 8'd1);
        bus_i.issue_ready = 1'b1;
        bus_i.enq_valid   = 1'b1;
        bus_i.wake_vec    = 4'b0001;
        #1;
        chk("c2_enq_we",    8'(bus_i.enq_we),    8'h02);
        chk("c2_shift_sel", 8'(bus_i.shift_sel), 8'h00);
        step();
        idle_inputs();
        #1;
        chk("c2_count_after", 8'(bus_i.count),       8'd2);
        chk("c2_slot0_rdy",   8'(bus_i.issue_slot),  8'd0);
        chk("c2_vld_after",   8'(bus_i.issue_valid), 8'd1);

        // Back-pressure: nothing moves
        step();
        chk("bp_count", 8'(bus_i.count),      8'd2);
        chk("bp_slot",  8'(bus_i.issue_slot), 8'd0);

        // Asynchronous reset between edges
        bus_i.enq_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count",     8'(bus_i.count),       8'd0);
        chk("ar_empty",     8'(bus_i.empty),       8'd1);
        chk("ar_enq_ready", 8'(bus_i.enq_ready),   8'd1);
        chk("ar_issue_vld", 8'(bus_i.issue_valid), 8'd0);
        chk("ar_enq_we",    8'(bus_i.enq_we),      8'h00);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
